// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// buffers returned words in a small FIFO and hands them to decode.
// A flush empties the queue and poisons any read still in flight.
module instr_fetch #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned QDEPTH = 2    // 2 or 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [15:0]       PC,
   output logic              PC_EN,
   output logic [15:0]       MEM_ADDR,
   output logic              MEM_REQ,
   input  logic              MEM_ACK,
   input  logic [DATA_W-1:0] MEM_DATA,
   input  logic              FLUSH,
   output logic [DATA_W-1:0] IR,
   output logic              IR_VALID,
   input  logic              IR_READY
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e            state_q, state_d;
   logic              discard_q, discard_d;
   logic [15:0]       addr_q, addr_d;
   logic [DATA_W-1:0] queue_q [QDEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push, pop;

   // Fetch FSM next-state, memory handshake and PC increment strobe
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      addr_d    = addr_q;
      push      = 1'b0;
      PC_EN     = 1'b0;
      MEM_REQ   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if ((count_q < CNT_W'(QDEPTH)) && !FLUSH) begin
               state_d = StReq;
               addr_d  = PC;
            end
         end
         StReq: begin
            MEM_REQ = 1'b1;
            if (MEM_ACK) begin
               // A poisoned or same-cycle-flushed read completes but is dropped
               push      = !discard_q && !FLUSH;
               PC_EN     = push;
               discard_d = 1'b0;
               state_d   = StWait;
            end else if (FLUSH) begin
               discard_d = 1'b1;
            end
         end
         StWait: begin
            // One idle cycle lets the PC register settle before the next issue
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state, discard flag and memory address registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= StIdle;
         discard_q <= 1'b0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         addr_q    <= addr_d;
      end
   end

   assign MEM_ADDR = addr_q;
   assign IR_VALID = (count_q != '0);
   assign pop      = IR_VALID && IR_READY;
   // No bypass: IR only shows words already written into the queue
   assign IR       = IR_VALID ? queue_q[rd_ptr_q] : '0;

   // Queue pointers and occupancy; flush wins over any push or pop
   always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Queue storage; push is never raised while the queue is full
   always_ff @(posedge CLK) begin
      if (push && !RESET) begin
         queue_q[wr_ptr_q] <= MEM_DATA;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: drives the memory and decode sides by hand
// and compares outputs against hand-computed values, one cycle at a time.
module tb_instr_fetch;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned QDEPTH = 2;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [15:0]       PC;
   logic              PC_EN;
   logic [15:0]       MEM_ADDR;
   logic              MEM_REQ;
   logic              MEM_ACK;
   logic [DATA_W-1:0] MEM_DATA;
   logic              FLUSH;
   logic [DATA_W-1:0] IR;
   logic              IR_VALID;
   logic              IR_READY;

   int n_checks = 0;
   int n_fail   = 0;
   int pcen_total = 0;
   int pcen_base  = 0;

   always #5 CLK = ~CLK;

   instr_fetch #(
      .DATA_W(DATA_W),
      .QDEPTH(QDEPTH)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .PC      (PC),
      .PC_EN   (PC_EN),
      .MEM_ADDR(MEM_ADDR),
      .MEM_REQ (MEM_REQ),
      .MEM_ACK (MEM_ACK),
      .MEM_DATA(MEM_DATA),
      .FLUSH   (FLUSH),
      .IR      (IR),
      .IR_VALID(IR_VALID),
      .IR_READY(IR_READY)
   );

   // Count PC_EN pulses seen at each rising edge
   always @(posedge CLK) begin
      if (PC_EN === 1'b1) pcen_total <= pcen_total + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc;
      @(posedge CLK);
      #1;
   endtask

   // Leaves the DUT in cycle 0 (IDLE) with RESET low
   task automatic do_reset;
      RESET    = 1'b1;
      FLUSH    = 1'b0;
      MEM_ACK  = 1'b0;
      IR_READY = 1'b0;
      cyc;
      cyc;
      RESET     = 1'b0;
      pcen_base = pcen_total;
   endtask

   initial begin
      RESET    = 1'b1;
      PC       = 16'h0000;
      MEM_ACK  = 1'b0;
      MEM_DATA = '0;
      FLUSH    = 1'b1;
      IR_READY = 1'b1;
      cyc;
      cyc;
      check("rst_mem_req",  32'(MEM_REQ),  0);
      check("rst_pc_en",    32'(PC_EN),    0);
      check("rst_mem_addr", 32'(MEM_ADDR), 0);
      check("rst_ir",       32'(IR),       0);
      check("rst_ir_valid", 32'(IR_VALID), 0);

      // Single fetch, one wait cycle before ACK
      do_reset;
      #1;
      check("t1_c0_req", 32'(MEM_REQ), 0);
      cyc;
      check("t1_c1_req",   32'(MEM_REQ),  1);
      check("t1_c1_addr",  32'(MEM_ADDR), 0);
      check("t1_c1_pc_en", 32'(PC_EN),    0);
      cyc;
      MEM_DATA = 32'h1111_1111;
      MEM_ACK  = 1'b1;
      #1;
      check("t1_c2_pc_en",    32'(PC_EN),    1);
      check("t1_c2_no_bypass", 32'(IR_VALID), 0);
      cyc;
      MEM_ACK = 1'b0;
      PC      = 16'h0001;
      #1;
      check("t1_c3_ir",       32'(IR),       32'h1111_1111);
      check("t1_c3_ir_valid", 32'(IR_VALID), 1);
      check("t1_c3_req",      32'(MEM_REQ),  0);
      check("t1_c3_pc_en",    32'(PC_EN),    0);

      // Fill the queue with decode stalled
      cyc;
      check("t2_idle_req", 32'(MEM_REQ), 0);
      cyc;
      check("t2_req",  32'(MEM_REQ),  1);
      check("t2_addr", 32'(MEM_ADDR), 1);
      MEM_DATA = 32'h2222_2222;
      MEM_ACK  = 1'b1;
      #1;
      check("t2_pc_en", 32'(PC_EN), 1);
      cyc;
      MEM_ACK = 1'b0;
      PC      = 16'h0002;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("t2_full_req", 32'(MEM_REQ), 0);
         check("t2_full_ir",  32'(IR),      32'h1111_1111);
         cyc;
      end
      check("t2_pc_en_count", 32'(pcen_total - pcen_base), QDEPTH);
      IR_READY = 1'b1;
      cyc;
      check("t2_pop1_ir",    32'(IR),       32'h2222_2222);
      check("t2_pop1_valid", 32'(IR_VALID), 1);
      cyc;
      check("t2_pop2_valid", 32'(IR_VALID), 0);
      IR_READY = 1'b0;

      // FLUSH in IDLE blocks issue, then a slow ACK
      do_reset;
      PC    = 16'h0040;
      FLUSH = 1'b1;
      cyc;
      FLUSH = 1'b0;
      check("t3_flush_idle_req", 32'(MEM_REQ), 0);
      cyc;
      PC = 16'h0041;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_wait_req",   32'(MEM_REQ),  1);
         check("t3_wait_addr",  32'(MEM_ADDR), 16'h0040);
         check("t3_wait_pc_en", 32'(PC_EN),    0);
         cyc;
      end
      MEM_DATA = 32'h3333_3333;
      MEM_ACK  = 1'b1;
      #1;
      check("t3_ack_addr",  32'(MEM_ADDR), 16'h0040);
      check("t3_ack_pc_en", 32'(PC_EN),    1);
      cyc;
      MEM_ACK = 1'b0;
      #1;
      check("t3_done_req",    32'(MEM_REQ), 0);
      check("t3_ir",          32'(IR),      32'h3333_3333);
      check("t3_pc_en_count", 32'(pcen_total - pcen_base), 1);

      // FLUSH during REQ, late ACK is dropped and PC is reused
      do_reset;
      PC = 16'h0100;
      cyc;
      FLUSH = 1'b1;
      #1;
      check("t4_flush_req", 32'(MEM_REQ), 1);
      cyc;
      FLUSH = 1'b0;
      #1;
      check("t4_held_req",   32'(MEM_REQ), 1);
      check("t4_held_pc_en", 32'(PC_EN),   0);
      cyc;
      MEM_DATA = 32'hDEAD_BEEF;
      MEM_ACK  = 1'b1;
      #1;
      check("t4_ack_pc_en", 32'(PC_EN), 0);
      cyc;
      MEM_ACK = 1'b0;
      #1;
      check("t4_ir_valid", 32'(IR_VALID), 0);
      check("t4_ir",       32'(IR),       0);
      check("t4_wait_req", 32'(MEM_REQ),  0);
      cyc;
      cyc;
      check("t4_reissue_req",  32'(MEM_REQ),  1);
      check("t4_reissue_addr", 32'(MEM_ADDR), 16'h0100);
      MEM_DATA = 32'h4444_4444;
      MEM_ACK  = 1'b1;
      #1;
      check("t4_reissue_pc_en", 32'(PC_EN), 1);
      cyc;
      MEM_ACK = 1'b0;
      PC      = 16'h0101;
      #1;
      check("t4_reissue_ir", 32'(IR), 32'h4444_4444);
      // FLUSH coincident with ACK: data dropped, queue emptied
      cyc;
      cyc;
      check("t4b_req", 32'(MEM_REQ), 1);
      MEM_DATA = 32'h5555_5555;
      MEM_ACK  = 1'b1;
      FLUSH    = 1'b1;
      #1;
      check("t4b_pc_en", 32'(PC_EN), 0);
      cyc;
      MEM_ACK = 1'b0;
      FLUSH   = 1'b0;
      #1;
      check("t4b_ir_valid",    32'(IR_VALID), 0);
      check("t4b_pc_en_count", 32'(pcen_total - pcen_base), 1);

      // Simultaneous push and pop with one word queued
      do_reset;
      PC = 16'h0200;
      cyc;
      cyc;
      MEM_DATA = 32'hAAAA_0001;
      MEM_ACK  = 1'b1;
      cyc;
      MEM_ACK = 1'b0;
      PC      = 16'h0201;
      cyc;
      cyc;
      check("t5_req",  32'(MEM_REQ),  1);
      check("t5_addr", 32'(MEM_ADDR), 16'h0201);
      MEM_DATA = 32'hAAAA_0002;
      MEM_ACK  = 1'b1;
      IR_READY = 1'b1;
      #1;
      check("t5_head_ir", 32'(IR), 32'hAAAA_0001);
      cyc;
      MEM_ACK  = 1'b0;
      IR_READY = 1'b0;
      #1;
      check("t5_after_ir",    32'(IR),       32'hAAAA_0002);
      check("t5_after_valid", 32'(IR_VALID), 1);
      IR_READY = 1'b1;
      cyc;
      IR_READY = 1'b0;
      #1;
      check("t5_count_one", 32'(IR_VALID), 0);

      // RESET mid-REQ, ACK arrives in IDLE and is ignored
      do_reset;
      PC = 16'h0300;
      cyc;
      check("t6_req", 32'(MEM_REQ), 1);
      RESET = 1'b1;
      cyc;
      RESET    = 1'b0;
      MEM_DATA = 32'hBBBB_BBBB;
      MEM_ACK  = 1'b1;
      #1;
      check("t6_pc_en",    32'(PC_EN),    0);
      check("t6_mem_req",  32'(MEM_REQ),  0);
      check("t6_mem_addr", 32'(MEM_ADDR), 0);
      check("t6_ir",       32'(IR),       0);
      check("t6_ir_valid", 32'(IR_VALID), 0);
      cyc;
      MEM_ACK = 1'b0;
      #1;
      check("t6_no_push",      32'(IR_VALID), 0);
      check("t6_pc_en_count",  32'(pcen_total - pcen_base), 0);
      check("t6_reissue_addr", 32'(MEM_ADDR), 16'h0300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-002 Parameter QDEPTH, default 2, SHALL set the instruction queue depth; legal values are 2 or 4.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be the synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 PC  input  16  SHALL carry the current program counter from the PC register.
REQ-006 PC_EN  output  1  SHALL be a one-cycle increment strobe to the PC register.
REQ-007 MEM_ADDR  output  16  SHALL carry the instruction memory read address.
REQ-008 MEM_REQ  output  1  SHALL be the read request, held until acknowledged.
REQ-009 MEM_ACK  input  1  SHALL indicate that MEM_DATA is valid and the request is complete.
REQ-010 MEM_DATA  input  DATA_W  SHALL carry the read instruction word.
REQ-011 FLUSH  input  1  SHALL discard queued and in-flight instructions.
REQ-012 IR  output  DATA_W  SHALL present the queue-head instruction to decode.
REQ-013 IR_VALID  output  1  SHALL be high when IR holds a valid instruction.
REQ-014 IR_READY  input  1  SHALL be high when decode accepts IR this cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-016 IDLE->REQ SHALL occur when count<QDEPTH and FLUSH=0; MEM_ADDR SHALL load PC on that edge.
REQ-017 In REQ, MEM_REQ SHALL be 1 and MEM_ADDR SHALL be held stable until MEM_ACK=1.
REQ-018 In REQ with MEM_ACK=1 and discard=0, MEM_DATA SHALL be pushed to the queue and PC_EN SHALL be 1 for that cycle only; next state SHALL be WAIT.
REQ-019 WAIT SHALL last exactly one cycle (PC settles) and then go to IDLE; MEM_REQ=0 and PC_EN=0 in WAIT.
REQ-020 MEM_REQ SHALL deassert on the edge after MEM_ACK; at most one request SHALL be outstanding.
REQ-021 Minimum issue interval SHALL be 3 cycles per instruction (IDLE, REQ, WAIT).
REQ-022 The queue SHALL be a QDEPTH-entry FIFO; IR = head entry; IR_VALID = (count!=0).
REQ-023 A pop SHALL occur when IR_VALID=1 and IR_READY=1; IR/IR_VALID SHALL be stable while IR_VALID=1 and IR_READY=0.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 A pushed word SHALL appear on IR no earlier than the cycle after MEM_ACK (no bypass).
REQ-026 Because issue requires count<QDEPTH, a push to a full queue SHALL never occur.
REQ-027 FLUSH=1 SHALL clear count to 0 on the next edge, overriding any same-cycle push or pop.
REQ-028 FLUSH=1 while in REQ SHALL set a discard flag; the later MEM_ACK SHALL complete the handshake, drop MEM_DATA, suppress PC_EN, and clear the flag.
REQ-029 FLUSH=1 coincident with MEM_ACK SHALL drop the data and suppress PC_EN.
REQ-030 FLUSH=1 in IDLE SHALL block issue in that cycle.

Reset
REQ-031 RESET=1 SHALL override FLUSH and all other inputs.
REQ-032 RESET SHALL force the FSM to IDLE, count=0, discard=0, MEM_REQ=0, PC_EN=0, MEM_ADDR=0, IR=0 and IR_VALID=0.
REQ-033 RESET asserted mid-REQ SHALL abandon the request; a late MEM_ACK arriving in IDLE SHALL be ignored.

Verification
REQ-034 Reset then PC=0x0000, memory returns 0x11111111 with 1-cycle ACK -> MEM_REQ rises cycle 1, PC_EN pulse cycle 2, IR=0x11111111 with IR_VALID cycle 3.
REQ-035 IR_READY=0, PC sequence 0,1,2 -> exactly QDEPTH words queued, MEM_REQ stays 0 when full, PC_EN pulsed QDEPTH times.
REQ-036 ACK delayed 4 cycles -> MEM_REQ high and MEM_ADDR constant for 4 cycles, single PC_EN pulse.
REQ-037 FLUSH in REQ, ACK two cycles later with 0xDEADBEEF -> no PC_EN, IR_VALID stays 0, next request reuses the same PC.
REQ-038 Push and pop in the same cycle with count=1 -> count stays 1, order preserved.
REQ-039 RESET in REQ, MEM_ACK next cycle -> all outputs at reset values, no push, no PC_EN.
